fsm_light_sequencer: RTL and testbench

FSM_LIGHT_SEQUENCER -- requirements
Module: fsm_light_sequencer

---
 rtl/fsm_light_sequencer.sv | 134 +++++++++++++
 tb/tb_fsm_light_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_light_sequencer.sv
// Traffic-light phase sequencer driving an external interval timer.
// Optional pedestrian request shortening GREEN: define PED_REQUEST_EN.
module fsm_light_sequencer #(
    parameter int RED_TICKS       = 4,
    parameter int RED_AMBER_TICKS = 1,
    parameter int GREEN_TICKS     = 4,
    parameter int AMBER_TICKS     = 2
) (
    input  logic       CLK,
    input  logic       N_RESET,
    input  logic       READY,
    input  logic       REQ,
    output logic       START,
    output logic       RESET,
    output logic       RED,
    output logic       AMBER,
    output logic       GREEN,
    output logic [1:0] PHASE,
    output logic       PED_WAIT
);

    typedef enum logic [1:0] {
        PH_RED, PH_RED_AMBER, PH_GREEN, PH_AMBER
    } phase_t;

    typedef enum logic [1:0] {
        ST_INIT, ST_ARM, ST_WAIT, ST_ACK
    } step_t;

    phase_t     phase, phase_nxt;
    step_t      step, step_nxt;
    logic [7:0] ticks, ticks_nxt;
    logic       cut;

`ifdef PED_REQUEST_EN
    logic ped, ped_nxt;
`else
    logic unused_req;
    assign unused_req = REQ;
`endif

    function automatic phase_t succ(input phase_t p);
        phase_t r;
        r = PH_RED;
        case (p)
            PH_RED:       r = PH_RED_AMBER;
            PH_RED_AMBER: r = PH_GREEN;
            PH_GREEN:     r = PH_AMBER;
            PH_AMBER:     r = PH_RED;
            default:      r = PH_RED;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] load(input phase_t p);
        logic [7:0] r;
        r = 8'(RED_TICKS);
        case (p)
            PH_RED:       r = 8'(RED_TICKS);
            PH_RED_AMBER: r = 8'(RED_AMBER_TICKS);
            PH_GREEN:     r = 8'(GREEN_TICKS);
            PH_AMBER:     r = 8'(AMBER_TICKS);
            default:      r = 8'(RED_TICKS);
        endcase
        return r;
    endfunction

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            phase <= PH_RED;
            step  <= ST_INIT;
            ticks <= 8'(RED_TICKS);
`ifdef PED_REQUEST_EN
            ped   <= 1'b0;
`endif
        end else begin
            phase <= phase_nxt;
            step  <= step_nxt;
            ticks <= ticks_nxt;
`ifdef PED_REQUEST_EN
            ped   <= ped_nxt;
`endif
        end
    end

    always_comb begin
        phase_nxt = phase;
        step_nxt  = step;
        ticks_nxt = ticks;
`ifdef PED_REQUEST_EN
        cut = ped && (phase == PH_GREEN);
`else
        cut = 1'b0;
`endif
        case (step)
            ST_INIT: step_nxt = ST_ARM;
            ST_ARM:  step_nxt = ST_WAIT;
            ST_WAIT: if (READY) step_nxt = ST_ACK;
            ST_ACK: begin
                step_nxt = ST_ARM;
                if (ticks > 8'd1 && !cut) begin
                    ticks_nxt = ticks - 8'd1;
                end else begin
                    phase_nxt = succ(phase);
                    ticks_nxt = load(succ(phase));
                end
            end
            default: step_nxt = ST_INIT;
        endcase
`ifdef PED_REQUEST_EN
        // Clear on RED entry takes priority over a same-cycle request.
        ped_nxt = ped;
        if (phase_nxt == PH_RED && phase != PH_RED)
            ped_nxt = 1'b0;
        else if (REQ && phase != PH_RED)
            ped_nxt = 1'b1;
`endif
    end

    always_comb begin
        START = (step == ST_ARM);
        RESET = (step == ST_INIT) || (step == ST_ACK);
        RED   = (phase == PH_RED) || (phase == PH_RED_AMBER);
        AMBER = (phase == PH_RED_AMBER) || (phase == PH_AMBER);
        GREEN = (phase == PH_GREEN);
        PHASE = phase;
`ifdef PED_REQUEST_EN
        PED_WAIT = ped;
`else
        PED_WAIT = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fsm_light_sequencer.sv
// Bench for fsm_light_sequencer with an N=4 interval timer model.
// Timing expectations come from phase lengths computed arithmetically.
module tb_fsm_light_sequencer;

    localparam int N   = 4;
    localparam int P   = N + 1;
    localparam int RT  = 2;
    localparam int RAT = 1;
    localparam int GT  = 3;
    localparam int AT  = 1;

    logic       CLK = 1'b0;
    logic       N_RESET;
    logic       READY;
    logic       REQ;
    logic       START;
    logic       RESET;
    logic       RED;
    logic       AMBER;
    logic       GREEN;
    logic [1:0] PHASE;
    logic       PED_WAIT;

    int vectors    = 0;
    int miscompares = 0;
    int t          = 0;

    logic tmr_armed, tmr_rdy, force_rdy;
    int   tmr_cnt;
    logic [7:0] obs;

    always #5 CLK = ~CLK;

    fsm_light_sequencer #(
        .RED_TICKS(RT),
        .RED_AMBER_TICKS(RAT),
        .GREEN_TICKS(GT),
        .AMBER_TICKS(AT)
    ) dut (
        .CLK(CLK),
        .N_RESET(N_RESET),
        .READY(READY),
        .REQ(REQ),
        .START(START),
        .RESET(RESET),
        .RED(RED),
        .AMBER(AMBER),
        .GREEN(GREEN),
        .PHASE(PHASE),
        .PED_WAIT(PED_WAIT)
    );

    // Timer: READY rises N-1 cycles after the START cycle, held until cleared.
    always @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            tmr_armed <= 1'b0;
            tmr_rdy   <= 1'b0;
            tmr_cnt   <= 0;
        end else if (RESET) begin
            tmr_armed <= 1'b0;
            tmr_rdy   <= 1'b0;
            tmr_cnt   <= 0;
        end else if (START) begin
            tmr_armed <= 1'b1;
            tmr_cnt   <= 1;
        end else if (tmr_armed && !tmr_rdy) begin
            tmr_cnt <= tmr_cnt + 1;
            if (tmr_cnt + 1 == N - 1) tmr_rdy <= 1'b1;
        end
    end

    assign READY = tmr_rdy | force_rdy;
    assign obs = {RED, AMBER, GREEN, PHASE, START, RESET, PED_WAIT};

    // Expected outputs at cycle t after reset release (no pedestrian activity).
    function automatic logic [7:0] model(input int tc);
        int len[4];
        int total, u, p, o;
        logic s, r, lr, la, lg;
        len[0] = RT * P;
        len[1] = RAT * P;
        len[2] = GT * P;
        len[3] = AT * P;
        total = len[0] + len[1] + len[2] + len[3];
        p = 0;
        if (tc == 0) begin
            s = 1'b0;
            r = 1'b1;
        end else begin
            u = (tc - 1) % total;
            while (u >= len[p]) begin
                u = u - len[p];
                p = p + 1;
            end
            o = u % P;
            s = (o == 0);
            r = (o == P - 1);
        end
        lr = (p == 0) || (p == 1);
        la = (p == 1) || (p == 3);
        lg = (p == 2);
        return {lr, la, lg, 2'(p), s, r, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s t=%0d: observed %b expected %b", tag, t, o, e);
        end
    endtask

    task automatic run_cycle(input string tag);
        logic [7:0] e;
        e = model(t);
        chk(tag, obs, e);
`ifdef PED_REQUEST_EN
        REQ = 1'b0;
`else
        REQ = 1'($urandom);
`endif
        // Spurious READY outside WAIT must have no effect.
        force_rdy = (e[2] || e[1]) ? 1'($urandom) : 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        t++;
    endtask

    initial begin
        int k;
        N_RESET   = 1'b0;
        REQ       = 1'b0;
        force_rdy = 1'b0;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            REQ       = 1'($urandom);
            force_rdy = 1'($urandom);
            #1 chk("in_reset", obs, model(0));
            @(negedge CLK);
        end
        REQ       = 1'b0;
        force_rdy = 1'b0;

        for (int rep = 0; rep < 4; rep++) begin
            N_RESET = 1'b1;
            t = 0;
            k = (rep == 0) ? 80 : int'($urandom_range(30, 17));
            repeat (k) run_cycle("seq");
            chk("pre_rst", obs, model(t));
            force_rdy = 1'b0;
            N_RESET   = 1'b0;
            #1 chk("async_rst", obs, model(0));
            @(posedge CLK);
            @(negedge CLK);
            chk("rst_hold", obs, model(0));
        end

`ifdef PED_REQUEST_EN
        N_RESET = 1'b1;
        t = 0;
        repeat (17) run_cycle("ped_pre");
        chk("ped_g2", obs, model(t));
        REQ = 1'b1;
        force_rdy = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        t++;
        REQ = 1'b0;
        while (t <= 27) begin
            logic [1:0] ep;
            logic       ew;
            ep = (t <= 20) ? 2'd2 : (t <= 25) ? 2'd3 : 2'd0;
            ew = (t <= 25);
            chk("ped", {5'b0, PHASE, PED_WAIT}, {5'b0, ep, ew});
            REQ = (t == 25);
            @(posedge CLK);
            @(negedge CLK);
            t++;
        end
        REQ = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
